// File: rtl/credit_manager.sv
// Upstream credit stage of the vending path: accepts coins, deducts vend prices,
// shows credit as BCD/7-segment digits and pays refunds one coin per cycle.
module credit_manager #(
  parameter int PRICE_A    = 25,
  parameter int PRICE_B    = 40,
  parameter int PRICE_C    = 55,
  parameter int PRICE_D    = 75,
  parameter int MAX_CREDIT = 95
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin,
  input  logic       refund_req,
  input  logic       vend_apple,
  input  logic       vend_banana,
  input  logic       vend_carrot,
  input  logic       vend_date,
  output logic [3:0] dig_tens,
  output logic [3:0] dig_ones,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       coin_reject,
  output logic       fault,
  output logic [1:0] change_out,
  output logic       busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFUND = 1'b1;

  localparam logic [6:0] P_A     = 7'(PRICE_A);
  localparam logic [6:0] P_B     = 7'(PRICE_B);
  localparam logic [6:0] P_C     = 7'(PRICE_C);
  localparam logic [6:0] P_D     = 7'(PRICE_D);
  localparam logic [7:0] MAX_C   = 8'(MAX_CREDIT);

  if ((PRICE_A % 5 != 0) || (PRICE_A > MAX_CREDIT) ||
      (PRICE_B % 5 != 0) || (PRICE_B > MAX_CREDIT) ||
      (PRICE_C % 5 != 0) || (PRICE_C > MAX_CREDIT) ||
      (PRICE_D % 5 != 0) || (PRICE_D > MAX_CREDIT) ||
      (MAX_CREDIT % 5 != 0) || (MAX_CREDIT > 99)) begin : g_cfg_err
    $error("credit_manager: invalid price/credit configuration");
  end

  function automatic logic [7:0] to_bcd(input logic [6:0] c);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(c / 7'd10);
    o = 4'(c % 7'd10);
    return {t, o};
  endfunction

  function automatic logic [6:0] to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [0:0] state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic       coin_reject_q, coin_reject_d;
  logic       fault_q, fault_d;
  logic [1:0] change_q, change_d;

  logic [3:0] vend_vec;
  logic       any_vend;
  logic       multi_vend;
  logic [6:0] price;
  logic [6:0] coin_val;
  logic [7:0] coin_sum;

  assign vend_vec   = {vend_apple, vend_banana, vend_carrot, vend_date};
  assign any_vend   = |vend_vec;
  assign multi_vend = (vend_vec & 4'(vend_vec - 4'd1)) != 4'd0;
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    price = 7'd0;
    case (vend_vec)
      4'b1000: price = P_A;
      4'b0100: price = P_B;
      4'b0010: price = P_C;
      4'b0001: price = P_D;
      default: price = 7'd0;
    endcase
  end

  always_comb begin
    coin_val = 7'd0;
    case (coin)
      2'b01:   coin_val = 7'd5;
      2'b10:   coin_val = 7'd10;
      2'b11:   coin_val = 7'd25;
      default: coin_val = 7'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    fault_d       = 1'b0;
    change_d      = 2'b00;
    case (state_q)
      IDLE: begin
        // Vends outrank refunds, which outrank coins; losers are rejected or dropped.
        if (any_vend) begin
          if (multi_vend || (credit_q < price)) fault_d = 1'b1;
          else                                  credit_d = credit_q - price;
          coin_reject_d = coin_valid;
        end else if (refund_req) begin
          if (credit_q != 7'd0) state_d = REFUND;
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if ((coin == 2'b00) || (coin_sum > MAX_C)) coin_reject_d = 1'b1;
          else                                        credit_d = coin_sum[6:0];
        end
      end
      default: begin
        coin_reject_d = coin_valid;
        fault_d       = any_vend;
        if (credit_q >= 7'd25) begin
          change_d = 2'b11;
          credit_d = credit_q - 7'd25;
        end else if (credit_q >= 7'd10) begin
          change_d = 2'b10;
          credit_d = credit_q - 7'd10;
        end else if (credit_q >= 7'd5) begin
          change_d = 2'b01;
          credit_d = credit_q - 7'd5;
        end else begin
          credit_d = 7'd0;
        end
        if (credit_d == 7'd0) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= 7'd0;
      coin_reject_q <= 1'b0;
      fault_q       <= 1'b0;
      change_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      fault_q       <= fault_d;
      change_q      <= change_d;
    end
  end

  assign {dig_tens, dig_ones} = to_bcd(credit_q);
  assign seg_tens    = to_seg(dig_tens);
  assign seg_ones    = to_seg(dig_ones);
  assign coin_reject = coin_reject_q;
  assign fault       = fault_q;
  assign change_out  = change_q;
  assign busy        = (state_q == REFUND);

endmodule

// File: tb/tb_credit_manager.sv
// Directed scoreboard bench for credit_manager: each step pushes the expected
// post-edge outputs and pops them after the edge for comparison.
module tb_credit_manager;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       refund_req = 1'b0;
  logic       vend_apple = 1'b0, vend_banana = 1'b0, vend_carrot = 1'b0, vend_date = 1'b0;
  logic [3:0] dig_tens, dig_ones;
  logic [6:0] seg_tens, seg_ones;
  logic       coin_reject, fault, busy;
  logic [1:0] change_out;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       rej;
    logic       flt;
    logic [1:0] chg;
    logic       bsy;
  } exp_t;
  exp_t sb[$];

  credit_manager dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
    .refund_req(refund_req), .vend_apple(vend_apple), .vend_banana(vend_banana),
    .vend_carrot(vend_carrot), .vend_date(vend_date), .dig_tens(dig_tens),
    .dig_ones(dig_ones), .seg_tens(seg_tens), .seg_ones(seg_ones),
    .coin_reject(coin_reject), .fault(fault), .change_out(change_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d < 4'd10) ? tbl[d] : 7'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".tens"}, 8'(dig_tens), 8'(e.tens));
    chk({tag, ".ones"}, 8'(dig_ones), 8'(e.ones));
    chk({tag, ".seg_tens"}, 8'(seg_tens), 8'(seg_of(e.tens)));
    chk({tag, ".seg_ones"}, 8'(seg_ones), 8'(seg_of(e.ones)));
    chk({tag, ".reject"}, 8'(coin_reject), 8'(e.rej));
    chk({tag, ".fault"}, 8'(fault), 8'(e.flt));
    chk({tag, ".change"}, 8'(change_out), 8'(e.chg));
    chk({tag, ".busy"}, 8'(busy), 8'(e.bsy));
  endtask

  // vend = {apple, banana, carrot, date}
  task automatic step(input string tag, input logic [3:0] vend, input logic cv,
                      input logic [1:0] cn, input logic rr,
                      input logic [3:0] et, input logic [3:0] eo, input logic er,
                      input logic ef, input logic [1:0] ec, input logic eb);
    exp_t e;
    @(negedge clk);
    {vend_apple, vend_banana, vend_carrot, vend_date} = vend;
    coin_valid = cv;
    coin       = cn;
    refund_req = rr;
    e = '{tens: et, ones: eo, rej: er, flt: ef, chg: ec, bsy: eb};
    sb.push_back(e);
    @(posedge clk);
    #1;
    {vend_apple, vend_banana, vend_carrot, vend_date} = 4'b0000;
    coin_valid = 1'b0;
    coin       = 2'b00;
    refund_req = 1'b0;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s: scoreboard empty observed 0 expected 1", tag);
    end else begin
      check_all(tag, sb.pop_front());
    end
  endtask

  task automatic do_reset(input string tag);
    exp_t z;
    @(negedge clk);
    reset = 1'b1;
    #1;
    z = '{tens: 4'd0, ones: 4'd0, rej: 1'b0, flt: 1'b0, chg: 2'b00, bsy: 1'b0};
    check_all(tag, z);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset("rst0");

    // 1: reset mid-refund at credit 35 aborts the refund
    step("t1_c25", 4'b0000, 1, 2'b11, 0, 4'd2, 4'd5, 0, 0, 2'b00, 0);
    step("t1_c10", 4'b0000, 1, 2'b10, 0, 4'd3, 4'd5, 0, 0, 2'b00, 0);
    step("t1_ref", 4'b0000, 0, 2'b00, 1, 4'd3, 4'd5, 0, 0, 2'b00, 1);
    step("t1_pay", 4'b0000, 0, 2'b00, 0, 4'd1, 4'd0, 0, 0, 2'b11, 1);
    do_reset("t1_rst");
    step("t1_post", 4'b0000, 0, 2'b00, 0, 4'd0, 4'd0, 0, 0, 2'b00, 0);

    // 2: coin accumulation up to the ceiling
    step("t2_c25a", 4'b0000, 1, 2'b11, 0, 4'd2, 4'd5, 0, 0, 2'b00, 0);
    step("t2_c25b", 4'b0000, 1, 2'b11, 0, 4'd5, 4'd0, 0, 0, 2'b00, 0);
    step("t2_c10",  4'b0000, 1, 2'b10, 0, 4'd6, 4'd0, 0, 0, 2'b00, 0);
    step("t2_c25c", 4'b0000, 1, 2'b11, 0, 4'd8, 4'd5, 0, 0, 2'b00, 0);
    step("t2_over", 4'b0000, 1, 2'b11, 0, 4'd8, 4'd5, 1, 0, 2'b00, 0);
    step("t2_max",  4'b0000, 1, 2'b10, 0, 4'd9, 4'd5, 0, 0, 2'b00, 0);
    step("t2_over5", 4'b0000, 1, 2'b01, 0, 4'd9, 4'd5, 1, 0, 2'b00, 0);

    // 3: vend deduction and insufficient credit
    do_reset("t3_rst");
    step("t3_c25a", 4'b0000, 1, 2'b11, 0, 4'd2, 4'd5, 0, 0, 2'b00, 0);
    step("t3_c25b", 4'b0000, 1, 2'b11, 0, 4'd5, 4'd0, 0, 0, 2'b00, 0);
    step("t3_c10",  4'b0000, 1, 2'b10, 0, 4'd6, 4'd0, 0, 0, 2'b00, 0);
    step("t3_ban",  4'b0100, 0, 2'b00, 0, 4'd2, 4'd0, 0, 0, 2'b00, 0);
    step("t3_date", 4'b0001, 0, 2'b00, 0, 4'd2, 4'd0, 0, 1, 2'b00, 0);

    // 4: refund of 65 pays 25,25,10,5; a coin during refund is rejected
    do_reset("t4_rst");
    step("t4_c25a", 4'b0000, 1, 2'b11, 0, 4'd2, 4'd5, 0, 0, 2'b00, 0);
    step("t4_c25b", 4'b0000, 1, 2'b11, 0, 4'd5, 4'd0, 0, 0, 2'b00, 0);
    step("t4_c10",  4'b0000, 1, 2'b10, 0, 4'd6, 4'd0, 0, 0, 2'b00, 0);
    step("t4_c5",   4'b0000, 1, 2'b01, 0, 4'd6, 4'd5, 0, 0, 2'b00, 0);
    step("t4_ref",  4'b0000, 0, 2'b00, 1, 4'd6, 4'd5, 0, 0, 2'b00, 1);
    step("t4_p25a", 4'b0000, 0, 2'b00, 0, 4'd4, 4'd0, 0, 0, 2'b11, 1);
    step("t4_p25b", 4'b0000, 1, 2'b10, 0, 4'd1, 4'd5, 1, 0, 2'b11, 1);
    step("t4_p10",  4'b1000, 0, 2'b00, 0, 4'd0, 4'd5, 0, 1, 2'b10, 1);
    step("t4_p5",   4'b0000, 0, 2'b00, 0, 4'd0, 4'd0, 0, 0, 2'b01, 0);
    step("t4_idle", 4'b0000, 0, 2'b00, 0, 4'd0, 4'd0, 0, 0, 2'b00, 0);

    // 5: vend with simultaneous coin; double vend pulse
    do_reset("t5_rst");
    step("t5_c25",  4'b0000, 1, 2'b11, 0, 4'd2, 4'd5, 0, 0, 2'b00, 0);
    step("t5_c5",   4'b0000, 1, 2'b01, 0, 4'd3, 4'd0, 0, 0, 2'b00, 0);
    step("t5_vcoin", 4'b1000, 1, 2'b10, 0, 4'd0, 4'd5, 1, 0, 2'b00, 0);
    step("t5_dbl",  4'b1100, 0, 2'b00, 0, 4'd0, 4'd5, 0, 1, 2'b00, 0);

    // 6: invalid coin code; refund at zero credit
    step("t6_c00",  4'b0000, 1, 2'b00, 0, 4'd0, 4'd5, 1, 0, 2'b00, 0);
    do_reset("t6_rst");
    step("t6_ref0", 4'b0000, 0, 2'b00, 1, 4'd0, 4'd0, 0, 0, 2'b00, 0);
    step("t6_idle", 4'b0000, 0, 2'b00, 0, 4'd0, 4'd0, 0, 0, 2'b00, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
